// File: rtl/mesh_task_scheduler.sv
// mesh_task_scheduler
//   Runs one traffic task on the 2x4 mesh: accepts a descriptor from the host,
//   flushes the selected PEs, loads their configuration, enables them, and
//   waits for every participating PE to report send/receive completion. A
//   hung task is timed out, and the host may abort at any point before the
//   end of RUN. Either way the PEs are flushed again before done is raised.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   cfg_valid/cfg_ready          descriptor handshake (ready only in IDLE)
//   cfg_pe_mask                  participating PEs
//   cfg_dbg_mode .. cfg_mode     per-PE configuration fields
//   abort                        host abort request
//   pe_*_wire, pe_enable         configuration/control driven to the mesh
//   pe_task_*_finish_flag        per-PE finish flags from the mesh
//   busy, done, status           task progress and result (1 ok, 2 timeout, 3 abort)
//   run_cycles                   RUN-state cycles of the last task

// Per-PE completion term. A PE outside the task never holds completion back.
module mesh_pe_done_chk (
    input  logic       in_task,
    input  logic [2:0] send_num,
    input  logic [2:0] recv_num,
    input  logic       send_flag,
    input  logic       recv_flag,
    output logic       lane_done
);
    assign lane_done = !in_task ||
                       ((send_num == 3'd0 || send_flag) && (recv_num == 3'd0 || recv_flag));
endmodule

module mesh_task_scheduler #(
    parameter int FLUSH_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [7:0]       cfg_pe_mask,
    input  logic [7:0]       cfg_dbg_mode,
    input  logic [23:0]      cfg_send_num,
    input  logic [23:0]      cfg_receive_num,
    input  logic [31:0]      cfg_rate,
    input  logic [191:0]     cfg_dst_seq,
    input  logic [31:0]      cfg_mode,
    input  logic             abort,
    output logic [7:0]       pe_enable,
    output logic [7:0]       pe_dbg_mode_wire,
    output logic [23:0]      pe_send_num_wire,
    output logic [23:0]      pe_receive_num_wire,
    output logic [31:0]      pe_rate_wire,
    output logic [31:0]      pe_mode_wire,
    output logic [191:0]     pe_dst_seq_wire,
    output logic [7:0]       pe_flush_wire,
    input  logic [7:0]       pe_task_send_finish_flag,
    input  logic [7:0]       pe_task_receive_finish_flag,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] run_cycles
);
    localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       ST_OK   = 2'd1;
    localparam logic [1:0]       ST_TO   = 2'd2;
    localparam logic [1:0]       ST_ABT  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_LOAD, S_RUN, S_CLEAN, S_DONE} state_t;

    state_t           state;
    logic [FC_W-1:0]  fcnt;
    logic [CNT_W-1:0] run_cnt;

    // Descriptor shadow, captured on accept so the host may change cfg_* freely.
    logic [7:0]   sh_mask;
    logic [7:0]   sh_dbg;
    logic [23:0]  sh_send;
    logic [23:0]  sh_recv;
    logic [31:0]  sh_rate;
    logic [191:0] sh_dst;
    logic [31:0]  sh_mode;

    logic [7:0] lane_done;
    logic       complete;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        mesh_pe_done_chk u_chk (
            .in_task   (sh_mask[i]),
            .send_num  (sh_send[3*i +: 3]),
            .recv_num  (sh_recv[3*i +: 3]),
            .send_flag (pe_task_send_finish_flag[i]),
            .recv_flag (pe_task_receive_finish_flag[i]),
            .lane_done (lane_done[i])
        );
    end

    assign complete  = &lane_done;
    assign busy      = (state != S_IDLE);
    assign cfg_ready = rst_n && (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            fcnt                <= '0;
            run_cnt             <= '0;
            sh_mask             <= '0;
            sh_dbg              <= '0;
            sh_send             <= '0;
            sh_recv             <= '0;
            sh_rate             <= '0;
            sh_dst              <= '0;
            sh_mode             <= '0;
            pe_enable           <= '0;
            pe_flush_wire       <= '0;
            pe_dbg_mode_wire    <= '0;
            pe_send_num_wire    <= '0;
            pe_receive_num_wire <= '0;
            pe_rate_wire        <= '0;
            pe_dst_seq_wire     <= '0;
            pe_mode_wire        <= '0;
            done                <= 1'b0;
            status              <= '0;
            run_cycles          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        sh_mask       <= cfg_pe_mask;
                        sh_dbg        <= cfg_dbg_mode;
                        sh_send       <= cfg_send_num;
                        sh_recv       <= cfg_receive_num;
                        sh_rate       <= cfg_rate;
                        sh_dst        <= cfg_dst_seq;
                        sh_mode       <= cfg_mode;
                        pe_flush_wire <= cfg_pe_mask;
                        fcnt          <= '0;
                        status        <= '0;
                        state         <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (abort) begin
                        // flush is already asserted; CLEAN restarts its count
                        fcnt   <= '0;
                        status <= ST_ABT;
                        state  <= S_CLEAN;
                    end else if (fcnt == FC_LAST) begin
                        pe_flush_wire <= '0;
                        state         <= S_LOAD;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        pe_flush_wire <= sh_mask;
                        fcnt          <= '0;
                        status        <= ST_ABT;
                        state         <= S_CLEAN;
                    end else begin
                        pe_enable <= sh_mask;
                        run_cnt   <= CNT_W'(1);
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort || complete || run_cnt == TO_CNT) begin
                        pe_enable  <= '0;
                        run_cycles <= run_cnt;
                        if (!abort && complete) begin
                            done   <= 1'b1;
                            status <= ST_OK;
                            state  <= S_DONE;
                        end else begin
                            pe_flush_wire <= sh_mask;
                            fcnt          <= '0;
                            status        <= abort ? ST_ABT : ST_TO;
                            state         <= S_CLEAN;
                        end
                    end else if (run_cnt != '1) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_CLEAN: begin
                    if (fcnt == FC_LAST) begin
                        pe_flush_wire <= '0;
                        done          <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Config outputs switch to the shadow on leaving FLUSH (to LOAD or
            // CLEAN), so they are stable a cycle before enable and hold through
            // IDLE and the next FLUSH.
            if (state == S_FLUSH && (abort || fcnt == FC_LAST)) begin
                pe_dbg_mode_wire    <= sh_dbg;
                pe_send_num_wire    <= sh_send;
                pe_receive_num_wire <= sh_recv;
                pe_rate_wire        <= sh_rate;
                pe_dst_seq_wire     <= sh_dst;
                pe_mode_wire        <= sh_mode;
            end
        end
    end
endmodule

// File: tb/tb_mesh_task_scheduler.sv
// Bench for mesh_task_scheduler: randomized descriptors and finish-flag timings,
// with expected phase timing, status and run_cycles derived from the task
// rules by a cycle-level walk over RUN cycles 1..TIMEOUT.
module tb_mesh_task_scheduler;
    localparam int FC = 4;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [7:0]   cfg_pe_mask = '0;
    logic [7:0]   cfg_dbg_mode = '0;
    logic [23:0]  cfg_send_num = '0;
    logic [23:0]  cfg_receive_num = '0;
    logic [31:0]  cfg_rate = '0;
    logic [191:0] cfg_dst_seq = '0;
    logic [31:0]  cfg_mode = '0;
    logic         abort = 1'b0;
    logic [7:0]   pe_enable, pe_dbg_mode_wire, pe_flush_wire;
    logic [23:0]  pe_send_num_wire, pe_receive_num_wire;
    logic [31:0]  pe_rate_wire, pe_mode_wire;
    logic [191:0] pe_dst_seq_wire;
    logic [7:0]   pe_task_send_finish_flag = '0;
    logic [7:0]   pe_task_receive_finish_flag = '0;
    logic         busy, done;
    logic [1:0]   status;
    logic [31:0]  run_cycles;

    mesh_task_scheduler #(.FLUSH_CYCLES(FC), .TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pe_mask(cfg_pe_mask), .cfg_dbg_mode(cfg_dbg_mode), .cfg_send_num(cfg_send_num),
        .cfg_receive_num(cfg_receive_num), .cfg_rate(cfg_rate), .cfg_dst_seq(cfg_dst_seq),
        .cfg_mode(cfg_mode), .abort(abort), .pe_enable(pe_enable),
        .pe_dbg_mode_wire(pe_dbg_mode_wire), .pe_send_num_wire(pe_send_num_wire),
        .pe_receive_num_wire(pe_receive_num_wire), .pe_rate_wire(pe_rate_wire),
        .pe_mode_wire(pe_mode_wire), .pe_dst_seq_wire(pe_dst_seq_wire),
        .pe_flush_wire(pe_flush_wire), .pe_task_send_finish_flag(pe_task_send_finish_flag),
        .pe_task_receive_finish_flag(pe_task_receive_finish_flag), .busy(busy), .done(done),
        .status(status), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Descriptor and flag timing for the next task. t_send/t_recv give the RUN
    // cycle from which a PE's flag reads 1 (0 = never); t_abort the RUN cycle
    // in which abort is asserted (0 = none).
    logic [7:0]   d_mask, d_dbg;
    logic [23:0]  d_snum, d_rnum;
    logic [31:0]  d_rate, d_mode;
    logic [191:0] d_dst;
    int           t_send[8];
    int           t_recv[8];
    int           t_abort;
    logic [311:0] prev_cfg = '0;
    wire  [311:0] obs_cfg = {pe_dbg_mode_wire, pe_send_num_wire, pe_receive_num_wire,
                             pe_rate_wire, pe_dst_seq_wire, pe_mode_wire};

    task automatic chk(input string tag, input logic [311:0] obs, input logic [311:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_desc(input logic [7:0] mask, input bit nonzero_counts);
        d_mask = mask;
        d_dbg  = 8'($urandom);
        d_rate = $urandom;
        d_mode = $urandom;
        d_dst  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            d_snum[3*i +: 3] = nonzero_counts ? 3'($urandom_range(1, 7)) : 3'($urandom);
            d_rnum[3*i +: 3] = nonzero_counts ? 3'($urandom_range(1, 7)) : 3'($urandom);
            t_send[i] = 0;
            t_recv[i] = 0;
        end
        t_abort = 0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle after done.
    task automatic run_task(input bit hold_valid, input string name);
        int kind, k_end, last, k;
        bit cmp, sf, rf;
        logic [311:0] new_cfg;
        logic [7:0] e_en, e_fl;
        logic e_done, e_busy;

        // Reference: first RUN cycle where abort, completion or timeout decides.
        kind = 0; k_end = 0;
        for (int kk = 1; kk <= TO && kind == 0; kk++) begin
            if (t_abort == kk) begin
                kind = 3; k_end = kk;
            end else begin
                cmp = 1'b1;
                for (int i = 0; i < 8; i++) if (d_mask[i]) begin
                    sf = (t_send[i] != 0) && (kk >= t_send[i]);
                    rf = (t_recv[i] != 0) && (kk >= t_recv[i]);
                    if (!(d_snum[3*i +: 3] == 3'd0 || sf) || !(d_rnum[3*i +: 3] == 3'd0 || rf))
                        cmp = 1'b0;
                end
                if (cmp) begin kind = 1; k_end = kk; end
                else if (kk == TO) begin kind = 2; k_end = kk; end
            end
        end
        // cycles after accept: 1..FC flush, FC+1 load, then RUN, [CLEAN], DONE
        last    = (kind == 1) ? FC + 2 + k_end : 2 * FC + 2 + k_end;
        new_cfg = {d_dbg, d_snum, d_rnum, d_rate, d_dst, d_mode};

        chk($sformatf("%s.ready_idle", name), 312'(cfg_ready), 312'(1));
        chk($sformatf("%s.busy_idle", name), 312'(busy), 312'(0));
        cfg_pe_mask = d_mask; cfg_dbg_mode = d_dbg; cfg_send_num = d_snum;
        cfg_receive_num = d_rnum; cfg_rate = d_rate; cfg_dst_seq = d_dst; cfg_mode = d_mode;
        cfg_valid = 1'b1;

        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            e_en = '0; e_fl = '0; e_done = 1'b0; e_busy = 1'b1;
            if (c <= FC) e_fl = d_mask;
            else if (c == FC + 1) e_fl = '0;
            else if (c <= FC + 1 + k_end) e_en = d_mask;
            else if (c == last) e_done = 1'b1;
            else if (c == last + 1) e_busy = 1'b0;
            else e_fl = d_mask;
            chk($sformatf("%s.en c%0d", name, c), 312'(pe_enable), 312'(e_en));
            chk($sformatf("%s.flush c%0d", name, c), 312'(pe_flush_wire), 312'(e_fl));
            chk($sformatf("%s.done c%0d", name, c), 312'(done), 312'(e_done));
            chk($sformatf("%s.busy c%0d", name, c), 312'(busy), 312'(e_busy));
            chk($sformatf("%s.ready c%0d", name, c), 312'(cfg_ready), 312'(!e_busy));
            if (c <= FC)
                chk($sformatf("%s.cfg_hold c%0d", name, c), obs_cfg, prev_cfg);
            else if (c == FC + 1 || c == last)
                chk($sformatf("%s.cfg c%0d", name, c), obs_cfg, new_cfg);
            if (c == 1)
                chk($sformatf("%s.status_clr", name), 312'(status), 312'(0));
            if (c == last) begin
                chk($sformatf("%s.status", name), 312'(status), 312'(kind));
                chk($sformatf("%s.run_cycles", name), 312'(run_cycles), 312'(k_end));
            end
            if (c == 1 && !hold_valid) cfg_valid = 1'b0;

            k = c - FC - 1;  // RUN cycle that the next posedge closes
            if (k >= 1 && k <= k_end) begin
                for (int i = 0; i < 8; i++) begin
                    pe_task_send_finish_flag[i] = d_mask[i] ?
                        ((t_send[i] != 0) && (k >= t_send[i])) : 1'($urandom);
                    pe_task_receive_finish_flag[i] = d_mask[i] ?
                        ((t_recv[i] != 0) && (k >= t_recv[i])) : 1'($urandom);
                end
            end else begin
                pe_task_send_finish_flag = '0;
                pe_task_receive_finish_flag = '0;
            end
            abort = (t_abort != 0) && (k == t_abort);
        end
        prev_cfg = new_cfg;
    endtask

    initial begin
        int j;
        #1;
        chk("rst.en", 312'(pe_enable), 312'(0));
        chk("rst.flush", 312'(pe_flush_wire), 312'(0));
        chk("rst.cfg", obs_cfg, 312'(0));
        chk("rst.busy", 312'(busy), 312'(0));
        chk("rst.done", 312'(done), 312'(0));
        chk("rst.status", 312'(status), 312'(0));
        chk("rst.run_cycles", 312'(run_cycles), 312'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.ready", 312'(cfg_ready), 312'(1));
        @(negedge clk);

        // basic: PE0 sends 3, PE3 receives 3, both flags from RUN cycle 10
        rand_desc(8'h09, 1'b0);
        d_snum[2:0] = 3'd3; d_rnum[2:0] = 3'd0;
        d_snum[11:9] = 3'd0; d_rnum[11:9] = 3'd3;
        t_send[0] = 10; t_recv[3] = 10;
        run_task(1'b0, "basic");

        // one receive flag never arrives -> timeout
        rand_desc(8'hFF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            t_send[i] = $urandom_range(1, 50); t_recv[i] = $urandom_range(1, 50);
        end
        j = $urandom_range(0, 7);
        t_recv[j] = 0;
        run_task(1'b0, "timeout");

        // last flag arrives exactly in the timeout cycle -> completion wins
        rand_desc(8'hFF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            t_send[i] = $urandom_range(1, 50); t_recv[i] = $urandom_range(1, 50);
        end
        j = $urandom_range(0, 7);
        t_recv[j] = TO;
        run_task(1'b0, "tie");

        // abort in RUN cycle 20
        rand_desc(8'($urandom) | 8'h01, 1'b1);
        t_abort = 20;
        run_task(1'b0, "abort");

        // empty mask, with cfg_valid held high through the task
        rand_desc(8'h00, 1'b1);
        run_task(1'b1, "empty");
        // next descriptor accepted the cycle after done
        rand_desc(8'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) begin
            t_send[i] = $urandom_range(1, 60); t_recv[i] = $urandom_range(1, 60);
        end
        run_task(1'b0, "back2back");

        // nonzero mask with all-zero counts completes in the first RUN cycle
        rand_desc(8'($urandom) | 8'h80, 1'b0);
        d_snum = '0; d_rnum = '0;
        run_task(1'b0, "zerocnt");

        for (int n = 0; n < 3; n++) begin
            rand_desc(8'($urandom), 1'b0);
            for (int i = 0; i < 8; i++) begin
                t_send[i] = $urandom_range(0, 120); t_recv[i] = $urandom_range(0, 120);
            end
            if ($urandom_range(0, 2) == 0) t_abort = $urandom_range(1, 100);
            run_task(1'b0, $sformatf("rand%0d", n));
        end

        // async reset while in RUN
        rand_desc(8'hA5, 1'b1);
        cfg_pe_mask = d_mask; cfg_send_num = d_snum; cfg_receive_num = d_rnum;
        cfg_dbg_mode = d_dbg; cfg_rate = d_rate; cfg_dst_seq = d_dst; cfg_mode = d_mode;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("midrst.en_before", 312'(pe_enable), 312'(8'hA5));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.en", 312'(pe_enable), 312'(0));
        chk("midrst.flush", 312'(pe_flush_wire), 312'(0));
        chk("midrst.cfg", obs_cfg, 312'(0));
        chk("midrst.busy", 312'(busy), 312'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst.ready", 312'(cfg_ready), 312'(1));
        chk("midrst.busy_after", 312'(busy), 312'(0));
        chk("midrst.status", 312'(status), 312'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
